// File: rtl/rename_pkg.sv
// Shared types and sizing for the two-wide rename stage.
//   ARCH_REGS / PHY_REGS : architectural and physical register counts
//   PHY_WIDTH / ARCH_WIDTH : tag and index widths
//   rename_slot_t : one renamed slot as held in the output register
//   PHY_ZERO : the tag permanently bound to x0
package rename_pkg;

    localparam int unsigned ARCH_REGS  = 32;
    localparam int unsigned PHY_REGS   = 64;
    localparam int unsigned PHY_WIDTH  = 6;
    localparam int unsigned ARCH_WIDTH = 5;
    localparam int unsigned FREE_WIDTH = PHY_WIDTH + 1;

    localparam logic [PHY_WIDTH-1:0] PHY_ZERO = '0;

    typedef struct packed {
        logic [PHY_WIDTH-1:0] ps1;
        logic [PHY_WIDTH-1:0] ps2;
        logic [PHY_WIDTH-1:0] pd;
        logic [PHY_WIDTH-1:0] pd_old;
        logic                 ps1_rdy;
        logic                 ps2_rdy;
    } rename_slot_t;

endpackage

// File: rtl/rat_table.sv
// Register alias table: ARCH_REGS entries of PHY_WIDTH-bit physical tags.
//   clk, rst       : clock, synchronous active-low reset (entry i <= i)
//   load/load_data : bulk restore of every entry (used on flush)
//   rd_addr/rd_data: four combinational source read ports
//   old_addr/old_data : two combinational reads of the current destination mapping
//   wr_en/wr_addr/wr_data : two ordered write ports; port 1 wins on a collision
module rat_table
    import rename_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  load,
    input  logic [ARCH_REGS-1:0][PHY_WIDTH-1:0]   load_data,
    input  logic [3:0][ARCH_WIDTH-1:0]            rd_addr,
    output logic [3:0][PHY_WIDTH-1:0]             rd_data,
    input  logic [1:0][ARCH_WIDTH-1:0]            old_addr,
    output logic [1:0][PHY_WIDTH-1:0]             old_data,
    input  logic [1:0]                            wr_en,
    input  logic [1:0][ARCH_WIDTH-1:0]            wr_addr,
    input  logic [1:0][PHY_WIDTH-1:0]             wr_data
);

    logic [ARCH_REGS-1:0][PHY_WIDTH-1:0] table_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                table_q[i] <= PHY_WIDTH'(i);
            end
        end else if (load) begin
            table_q <= load_data;
        end else begin
            if (wr_en[0]) table_q[wr_addr[0]] <= wr_data[0];
            // Later assignment: slot 1 wins on a same-rd collision.
            if (wr_en[1]) table_q[wr_addr[1]] <= wr_data[1];
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rd_data[i] = table_q[rd_addr[i]];
        end
        for (int i = 0; i < 2; i++) begin
            old_data[i] = table_q[old_addr[i]];
        end
    end

endmodule

// File: rtl/rename_stage.sv
// Two-wide rename stage between decode and dispatch. Owns the speculative
// front RAT (rat_table) and the committed RAT (local array), requests free
// physical tags per destination write, returns retired old mappings to the
// free list and restores the front RAT from the committed RAT on flush.
// Optional busy table compiled in with `define RENAME_BUSY_TABLE_EN.
//   clk, rst (sync, active-low), flush
//   dec_*   : decoded group in, dec_ready = group accepted this cycle
//   fl_*    : free-list allocation request/tags and commit strobe/tags
//   ren_*   : registered renamed group out, ren_ready from dispatch
//   wb_*    : writeback tag (clears busy bit)
//   retire_*: one retirement per cycle into the committed RAT
module rename_stage
    import rename_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [1:0]            dec_valid,
    output logic                  dec_ready,
    input  logic [ARCH_WIDTH-1:0] dec_rs1_0,
    input  logic [ARCH_WIDTH-1:0] dec_rs2_0,
    input  logic [ARCH_WIDTH-1:0] dec_rd_0,
    input  logic [ARCH_WIDTH-1:0] dec_rs1_1,
    input  logic [ARCH_WIDTH-1:0] dec_rs2_1,
    input  logic [ARCH_WIDTH-1:0] dec_rd_1,
    input  logic [1:0]            dec_rd_wen,
    input  logic [FREE_WIDTH-1:0] fl_num_free,
    output logic [1:0]            fl_valid,
    input  logic [PHY_WIDTH-1:0]  fl_phy_new_0,
    input  logic [PHY_WIDTH-1:0]  fl_phy_new_1,
    output logic [1:0]            ren_valid,
    input  logic                  ren_ready,
    output logic [PHY_WIDTH-1:0]  ren_ps1_0,
    output logic [PHY_WIDTH-1:0]  ren_ps2_0,
    output logic [PHY_WIDTH-1:0]  ren_pd_0,
    output logic [PHY_WIDTH-1:0]  ren_pd_old_0,
    output logic [PHY_WIDTH-1:0]  ren_ps1_1,
    output logic [PHY_WIDTH-1:0]  ren_ps2_1,
    output logic [PHY_WIDTH-1:0]  ren_pd_1,
    output logic [PHY_WIDTH-1:0]  ren_pd_old_1,
    output logic                  ren_ps1_rdy_0,
    output logic                  ren_ps2_rdy_0,
    output logic                  ren_ps1_rdy_1,
    output logic                  ren_ps2_rdy_1,
    input  logic                  wb_valid,
    input  logic [PHY_WIDTH-1:0]  wb_phy,
    input  logic                  retire_valid,
    input  logic [ARCH_WIDTH-1:0] retire_rd,
    input  logic [PHY_WIDTH-1:0]  retire_pd,
    output logic                  fl_retire_valid,
    output logic [PHY_WIDTH-1:0]  fl_phy_old_commit,
    output logic [PHY_WIDTH-1:0]  fl_phy_new_commit
);

    logic                  need0, need1, fire;
    logic [FREE_WIDTH-1:0] need;
    logic [1:0]            ren_valid_q;
    rename_slot_t [1:0]    slot_q, slot_d;
    logic [3:0][PHY_WIDTH-1:0] src_tag;
    logic [1:0][PHY_WIDTH-1:0] old_tag;
    logic [3:0]            src_rdy;
    logic [ARCH_REGS-1:0][PHY_WIDTH-1:0] crat_q, crat_d;

    assign need0 = dec_valid[0] & dec_rd_wen[0] & (dec_rd_0 != '0);
    assign need1 = dec_valid[1] & dec_rd_wen[1] & (dec_rd_1 != '0);
    assign need  = FREE_WIDTH'(need0) + FREE_WIDTH'(need1);

    // rst gates fire so nothing is accepted or allocated while in reset.
    assign fire = rst & (|dec_valid) & (~(|ren_valid_q) | ren_ready)
                & (fl_num_free >= need) & ~flush;

    assign dec_ready = fire;
    assign fl_valid  = {fire & need1, fire & need0};

    // Committed RAT; the flush restore sees a same-cycle retire via crat_d.
    assign fl_retire_valid   = retire_valid & (retire_rd != '0);
    assign fl_phy_old_commit = crat_q[retire_rd];
    assign fl_phy_new_commit = retire_pd;

    always_comb begin
        crat_d = crat_q;
        if (fl_retire_valid) crat_d[retire_rd] = retire_pd;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                crat_q[i] <= PHY_WIDTH'(i);
            end
        end else begin
            crat_q <= crat_d;
        end
    end

    // Entry 0 is never written (allocation and retire both skip x0), so
    // source x0 reads p0 straight from the table.
    rat_table u_front_rat (
        .clk       (clk),
        .rst       (rst),
        .load      (flush),
        .load_data (crat_d),
        .rd_addr   ({dec_rs2_1, dec_rs1_1, dec_rs2_0, dec_rs1_0}),
        .rd_data   (src_tag),
        .old_addr  ({dec_rd_1, dec_rd_0}),
        .old_data  (old_tag),
        .wr_en     ({fire & need1, fire & need0}),
        .wr_addr   ({dec_rd_1, dec_rd_0}),
        .wr_data   ({fl_phy_new_1, fl_phy_new_0})
    );

`ifdef RENAME_BUSY_TABLE_EN
    logic [PHY_REGS-1:0] busy_q, busy_vis;

    // A writeback in the same cycle is already visible to the rename.
    always_comb begin
        busy_vis = busy_q;
        if (wb_valid) busy_vis[wb_phy] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            src_rdy[i] = (src_tag[i] == PHY_ZERO) | ~busy_vis[src_tag[i]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_vis;
            if (fire && need0) busy_q[fl_phy_new_0] <= 1'b1;
            if (fire && need1) busy_q[fl_phy_new_1] <= 1'b1;
        end
    end
`else
    logic unused_wb;
    assign unused_wb = ^{wb_valid, wb_phy};
    assign src_rdy   = '0;
`endif

    always_comb begin
        slot_d = '0;
        if (dec_valid[0]) begin
            slot_d[0].ps1     = src_tag[0];
            slot_d[0].ps2     = src_tag[1];
            slot_d[0].ps1_rdy = src_rdy[0];
            slot_d[0].ps2_rdy = src_rdy[1];
            if (need0) begin
                slot_d[0].pd     = fl_phy_new_0;
                slot_d[0].pd_old = old_tag[0];
            end
        end
        if (dec_valid[1]) begin
            slot_d[1].ps1     = src_tag[2];
            slot_d[1].ps2     = src_tag[3];
            slot_d[1].ps1_rdy = src_rdy[2];
            slot_d[1].ps2_rdy = src_rdy[3];
            // Intra-group bypass: the producer is slot 0, so never ready yet.
            if (need0 && dec_rs1_1 == dec_rd_0) begin
                slot_d[1].ps1     = fl_phy_new_0;
                slot_d[1].ps1_rdy = 1'b0;
            end
            if (need0 && dec_rs2_1 == dec_rd_0) begin
                slot_d[1].ps2     = fl_phy_new_0;
                slot_d[1].ps2_rdy = 1'b0;
            end
            if (need1) begin
                slot_d[1].pd     = fl_phy_new_1;
                slot_d[1].pd_old = (need0 && dec_rd_1 == dec_rd_0) ? fl_phy_new_0 : old_tag[1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ren_valid_q <= '0;
            slot_q      <= '0;
        end else if (flush) begin
            ren_valid_q <= '0;
        end else if (fire) begin
            ren_valid_q <= dec_valid;
            slot_q      <= slot_d;
        end else if (ren_ready) begin
            ren_valid_q <= '0;
        end
    end

    assign ren_valid     = ren_valid_q;
    assign ren_ps1_0     = slot_q[0].ps1;
    assign ren_ps2_0     = slot_q[0].ps2;
    assign ren_pd_0      = slot_q[0].pd;
    assign ren_pd_old_0  = slot_q[0].pd_old;
    assign ren_ps1_rdy_0 = slot_q[0].ps1_rdy;
    assign ren_ps2_rdy_0 = slot_q[0].ps2_rdy;
    assign ren_ps1_1     = slot_q[1].ps1;
    assign ren_ps2_1     = slot_q[1].ps2;
    assign ren_pd_1      = slot_q[1].pd;
    assign ren_pd_old_1  = slot_q[1].pd_old;
    assign ren_ps1_rdy_1 = slot_q[1].ps1_rdy;
    assign ren_ps2_rdy_1 = slot_q[1].ps2_rdy;

endmodule

// File: tb/tb_rename_stage.sv
// Self-checking bench for rename_stage: directed steps followed by a random
// phase, all checked against a sequential reference model of the rename rules.
module tb_rename_stage;

`ifdef RENAME_BUSY_TABLE_EN
    localparam bit BUSY_EN = 1'b1;
`else
    localparam bit BUSY_EN = 1'b0;
`endif

    logic       clk, rst, flush;
    logic [1:0] dec_valid, dec_rd_wen;
    logic       dec_ready;
    logic [4:0] dec_rs1_0, dec_rs2_0, dec_rd_0, dec_rs1_1, dec_rs2_1, dec_rd_1;
    logic [6:0] fl_num_free;
    logic [1:0] fl_valid;
    logic [5:0] fl_phy_new_0, fl_phy_new_1;
    logic [1:0] ren_valid;
    logic       ren_ready;
    logic [5:0] ren_ps1_0, ren_ps2_0, ren_pd_0, ren_pd_old_0;
    logic [5:0] ren_ps1_1, ren_ps2_1, ren_pd_1, ren_pd_old_1;
    logic       ren_ps1_rdy_0, ren_ps2_rdy_0, ren_ps1_rdy_1, ren_ps2_rdy_1;
    logic       wb_valid;
    logic [5:0] wb_phy;
    logic       retire_valid;
    logic [4:0] retire_rd;
    logic [5:0] retire_pd;
    logic       fl_retire_valid;
    logic [5:0] fl_phy_old_commit, fl_phy_new_commit;

    rename_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_rs1_0(dec_rs1_0), .dec_rs2_0(dec_rs2_0), .dec_rd_0(dec_rd_0),
        .dec_rs1_1(dec_rs1_1), .dec_rs2_1(dec_rs2_1), .dec_rd_1(dec_rd_1),
        .dec_rd_wen(dec_rd_wen), .fl_num_free(fl_num_free), .fl_valid(fl_valid),
        .fl_phy_new_0(fl_phy_new_0), .fl_phy_new_1(fl_phy_new_1),
        .ren_valid(ren_valid), .ren_ready(ren_ready),
        .ren_ps1_0(ren_ps1_0), .ren_ps2_0(ren_ps2_0), .ren_pd_0(ren_pd_0),
        .ren_pd_old_0(ren_pd_old_0), .ren_ps1_1(ren_ps1_1), .ren_ps2_1(ren_ps2_1),
        .ren_pd_1(ren_pd_1), .ren_pd_old_1(ren_pd_old_1),
        .ren_ps1_rdy_0(ren_ps1_rdy_0), .ren_ps2_rdy_0(ren_ps2_rdy_0),
        .ren_ps1_rdy_1(ren_ps1_rdy_1), .ren_ps2_rdy_1(ren_ps2_rdy_1),
        .wb_valid(wb_valid), .wb_phy(wb_phy),
        .retire_valid(retire_valid), .retire_rd(retire_rd), .retire_pd(retire_pd),
        .fl_retire_valid(fl_retire_valid), .fl_phy_old_commit(fl_phy_old_commit),
        .fl_phy_new_commit(fl_phy_new_commit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0][5:0] o_ps1, o_ps2, o_pd, o_old;
    logic [1:0]      o_r1, o_r2;
    assign o_ps1 = {ren_ps1_1, ren_ps1_0};
    assign o_ps2 = {ren_ps2_1, ren_ps2_0};
    assign o_pd  = {ren_pd_1, ren_pd_0};
    assign o_old = {ren_pd_old_1, ren_pd_old_0};
    assign o_r1  = {ren_ps1_rdy_1, ren_ps1_rdy_0};
    assign o_r2  = {ren_ps2_rdy_1, ren_ps2_rdy_0};

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: front map, committed map, busy set, expected outputs.
    int       m_rat[32];
    int       m_crat[32];
    bit       m_busy[64];
    bit [1:0] m_valid = 2'b00;
    bit [1:0] m_mask  = 2'b00;
    int       m_ps1[2], m_ps2[2], m_pd[2], m_old[2];
    bit       m_r1[2], m_r2[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic defaults();
        rst = 1'b1; flush = 1'b0; dec_valid = 2'b00; dec_rd_wen = 2'b00;
        dec_rs1_0 = 0; dec_rs2_0 = 0; dec_rd_0 = 0;
        dec_rs1_1 = 0; dec_rs2_1 = 0; dec_rd_1 = 0;
        fl_num_free = 7'd32; fl_phy_new_0 = 6'd32; fl_phy_new_1 = 6'd33;
        ren_ready = 1'b1; wb_valid = 1'b0; wb_phy = 0;
        retire_valid = 1'b0; retire_rd = 0; retire_pd = 0;
    endtask

    // One clock: inputs are already driven; check combinational outputs at the
    // falling edge, advance the model across the rising edge, check registers.
    task automatic step();
        bit n0, n1, fire_e, strobe, alloc;
        int need, rs1v, rs2v, rdv, newv;
        int crat_new[32];
        int rat_t[32];
        bit wr[32];
        bit busy_wb[64];
        bit busy_t[64];
        int e_ps1[2], e_ps2[2], e_pd[2], e_old[2];
        bit e_r1[2], e_r2[2];

        n0 = dec_valid[0] && dec_rd_wen[0] && dec_rd_0 != 0;
        n1 = dec_valid[1] && dec_rd_wen[1] && dec_rd_1 != 0;
        need = int'(n0) + int'(n1);
        fire_e = rst && (dec_valid != 0) && (m_valid == 0 || ren_ready)
              && int'(fl_num_free) >= need && !flush;
        #4;
        chk("dec_ready", dec_ready, fire_e);
        chk("fl_valid", fl_valid, {fire_e & n1, fire_e & n0});
        strobe = retire_valid && retire_rd != 0;
        chk("fl_retire_valid", fl_retire_valid, strobe);
        if (strobe) begin
            chk("fl_phy_old_commit", fl_phy_old_commit, m_crat[retire_rd]);
            chk("fl_phy_new_commit", fl_phy_new_commit, retire_pd);
        end

        crat_new = m_crat;
        if (strobe) crat_new[retire_rd] = retire_pd;
        busy_wb = m_busy;
        if (BUSY_EN && wb_valid) busy_wb[wb_phy] = 1'b0;
        rat_t  = m_rat;
        busy_t = busy_wb;
        for (int i = 0; i < 32; i++) wr[i] = 1'b0;

        // Slot 0 renames and commits to the temporary map before slot 1 looks.
        for (int s = 0; s < 2; s++) begin
            rs1v = (s == 0) ? dec_rs1_0 : dec_rs1_1;
            rs2v = (s == 0) ? dec_rs2_0 : dec_rs2_1;
            rdv  = (s == 0) ? dec_rd_0  : dec_rd_1;
            newv = (s == 0) ? fl_phy_new_0 : fl_phy_new_1;
            e_ps1[s] = 0; e_ps2[s] = 0; e_pd[s] = 0; e_old[s] = 0;
            e_r1[s] = 0; e_r2[s] = 0;
            if (dec_valid[s]) begin
                e_ps1[s] = (rs1v == 0) ? 0 : rat_t[rs1v];
                e_ps2[s] = (rs2v == 0) ? 0 : rat_t[rs2v];
                e_r1[s]  = BUSY_EN && !wr[rs1v] && (e_ps1[s] == 0 || !busy_wb[e_ps1[s]]);
                e_r2[s]  = BUSY_EN && !wr[rs2v] && (e_ps2[s] == 0 || !busy_wb[e_ps2[s]]);
                alloc = dec_rd_wen[s] && rdv != 0;
                if (alloc) begin
                    e_old[s]   = rat_t[rdv];
                    e_pd[s]    = newv;
                    rat_t[rdv] = newv;
                    wr[rdv]    = 1'b1;
                    if (BUSY_EN) busy_t[newv] = 1'b1;
                end
            end
        end

        @(posedge clk);
        #1;
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin m_rat[i] = i; m_crat[i] = i; end
            for (int i = 0; i < 64; i++) m_busy[i] = 1'b0;
            m_valid = 2'b00; m_mask = 2'b11;
            for (int s = 0; s < 2; s++) begin
                m_ps1[s] = 0; m_ps2[s] = 0; m_pd[s] = 0; m_old[s] = 0;
                m_r1[s] = 0; m_r2[s] = 0;
            end
        end else begin
            m_crat = crat_new;
            if (flush) begin
                m_rat = crat_new;
                for (int i = 0; i < 64; i++) m_busy[i] = 1'b0;
                m_valid = 2'b00; m_mask = 2'b00;
            end else if (fire_e) begin
                m_rat = rat_t; m_busy = busy_t;
                m_valid = dec_valid; m_mask = dec_valid;
                m_ps1 = e_ps1; m_ps2 = e_ps2; m_pd = e_pd; m_old = e_old;
                m_r1 = e_r1; m_r2 = e_r2;
            end else begin
                m_busy = busy_wb;
                if (ren_ready) begin m_valid = 2'b00; m_mask = 2'b00; end
            end
        end

        chk("ren_valid", ren_valid, m_valid);
        for (int s = 0; s < 2; s++) begin
            if (m_mask[s]) begin
                chk($sformatf("ps1_%0d", s), o_ps1[s], m_ps1[s]);
                chk($sformatf("ps2_%0d", s), o_ps2[s], m_ps2[s]);
                chk($sformatf("pd_%0d", s), o_pd[s], m_pd[s]);
                chk($sformatf("pd_old_%0d", s), o_old[s], m_old[s]);
                chk($sformatf("ps1_rdy_%0d", s), o_r1[s], m_r1[s]);
                chk($sformatf("ps2_rdy_%0d", s), o_r2[s], m_r2[s]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin m_rat[i] = i; m_crat[i] = i; end
        for (int i = 0; i < 64; i++) m_busy[i] = 1'b0;
        defaults();
        rst = 1'b0;
        @(posedge clk);
        #1;
        // Reset with a group offered: nothing accepted, outputs cleared.
        dec_valid = 2'b11; dec_rd_wen = 2'b11; dec_rd_0 = 5'd3; dec_rd_1 = 5'd4;
        step();
        step();

        // Bypass group: x5 allocated twice, slot 1 reads x5.
        defaults();
        dec_valid = 2'b11; dec_rd_wen = 2'b11;
        dec_rd_0 = 5'd5; dec_rs1_1 = 5'd5; dec_rd_1 = 5'd5;
        fl_phy_new_0 = 6'd32; fl_phy_new_1 = 6'd33;
        step();
        chk("tp1_pd_0", ren_pd_0, 32);
        chk("tp1_pd_old_0", ren_pd_old_0, 5);
        chk("tp1_ps1_1", ren_ps1_1, 32);
        chk("tp1_pd_1", ren_pd_1, 33);
        chk("tp1_pd_old_1", ren_pd_old_1, 32);

        // Slot 1 wins the collision: x5 now maps to 33.
        defaults();
        dec_valid = 2'b01; dec_rs1_0 = 5'd5;
        step();
        chk("tp1_rat5", ren_ps1_0, 33);

        // Not enough free tags stalls the whole group; enough accepts it.
        defaults();
        dec_valid = 2'b11; dec_rd_wen = 2'b11; dec_rd_0 = 5'd3; dec_rd_1 = 5'd4;
        fl_phy_new_0 = 6'd35; fl_phy_new_1 = 6'd36; fl_num_free = 7'd1;
        step();
        fl_num_free = 7'd2;
        step();

        // Back-pressure: outputs hold for three cycles, then the next group flows.
        ren_ready = 1'b0;
        dec_valid = 2'b10; dec_rd_wen = 2'b10; dec_rs1_1 = 5'd3; dec_rd_1 = 5'd6;
        fl_phy_new_1 = 6'd37;
        step(); step(); step();
        ren_ready = 1'b1;
        step();
        defaults();
        step();

        // Speculative x5->40, retire x5->33, flush restores x5 to 33.
        dec_valid = 2'b01; dec_rd_wen = 2'b01; dec_rd_0 = 5'd5; fl_phy_new_0 = 6'd40;
        step();
        defaults();
        retire_valid = 1'b1; retire_rd = 5'd5; retire_pd = 6'd33;
        step();
        defaults();
        flush = 1'b1;
        step();
        defaults();
        dec_valid = 2'b01; dec_rs1_0 = 5'd5;
        step();
        chk("flush_restore_x5", ren_ps1_0, 33);

        // Flush with a same-cycle retire of x7->41.
        defaults();
        flush = 1'b1; retire_valid = 1'b1; retire_rd = 5'd7; retire_pd = 6'd41;
        dec_valid = 2'b01;
        step();
        defaults();
        dec_valid = 2'b01; dec_rs1_0 = 5'd7;
        step();
        chk("flush_retire_x7", ren_ps1_0, 41);

        // Busy tracking: allocate p34 for x9, read before and after writeback.
        defaults();
        dec_valid = 2'b01; dec_rd_wen = 2'b01; dec_rd_0 = 5'd9; fl_phy_new_0 = 6'd34;
        step();
        defaults();
        dec_valid = 2'b01; dec_rs1_0 = 5'd9;
        step();
        chk("busy_before_wb", ren_ps1_rdy_0, 0);
        defaults();
        wb_valid = 1'b1; wb_phy = 6'd34;
        step();
        defaults();
        dec_valid = 2'b01; dec_rs1_0 = 5'd9;
        step();
        chk("busy_after_wb", ren_ps1_rdy_0, BUSY_EN);

        // Retire to x0 produces no strobe.
        defaults();
        retire_valid = 1'b1; retire_rd = 5'd0; retire_pd = 6'd50;
        step();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            defaults();
            dec_valid    = 2'($urandom);
            dec_rd_wen   = 2'($urandom);
            dec_rs1_0    = 5'($urandom); dec_rs2_0 = 5'($urandom); dec_rd_0 = 5'($urandom);
            dec_rs1_1    = 5'($urandom); dec_rs2_1 = 5'($urandom); dec_rd_1 = 5'($urandom);
            if ($urandom_range(0, 3) == 0) dec_rs1_1 = dec_rd_0;
            if ($urandom_range(0, 3) == 0) dec_rd_1 = dec_rd_0;
            fl_num_free  = 7'($urandom_range(0, 3));
            fl_phy_new_0 = 6'($urandom_range(32, 63));
            fl_phy_new_1 = 6'($urandom_range(32, 63));
            ren_ready    = ($urandom_range(0, 9) < 7);
            flush        = ($urandom_range(0, 19) == 0);
            retire_valid = ($urandom_range(0, 2) == 0);
            retire_rd    = 5'($urandom);
            retire_pd    = 6'($urandom_range(1, 63));
            wb_valid     = ($urandom_range(0, 2) == 0);
            wb_phy       = 6'($urandom_range(32, 63));
            if (n == 300) rst = 1'b0;  // reset mid-operation discards the group
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rename_stage.md
# rename_stage

Two-wide register-rename stage between decode and dispatch. It owns the speculative front RAT and the committed RAT, and requests physical registers from the free list for each destination write. It returns retired old mappings to the free list and restores the front RAT from the committed RAT on flush.

## Interface
- ARCH_REGS, 32, architectural registers; x0 is hard-wired.
- PHY_REGS, 64, physical registers; p0 is permanently mapped to x0.
- PHY_WIDTH, 6, physical tag width.
- ARCH_WIDTH, 5, architectural index width.
- clk  in  1  clock.
- rst  in  1  reset, one clock, synchronous and active-low.
- flush  in  1  pipeline flush (mispredict/exception).
- dec_valid  in  2  per-slot valid. A slot 1 valid without slot 0 valid is legal.
- dec_ready  out  1  group accepted this cycle.
- dec_rs1_{0,1}, dec_rs2_{0,1}, dec_rd_{0,1}  in  ARCH_WIDTH  architectural sources and destination per slot.
- dec_rd_wen  in  2  per-slot destination write.
- fl_num_free  in  PHY_WIDTH+1  free-list entries available.
- fl_valid  out  2  allocation request; free-list slot-compaction rules apply.
- fl_phy_new_0, fl_phy_new_1  in  PHY_WIDTH  allocated tags, combinational on fl_valid.
- ren_valid  out  2  renamed slots valid.
- ren_ready  in  1  dispatch accepts.
- ren_ps1_{0,1}, ren_ps2_{0,1}, ren_pd_{0,1}, ren_pd_old_{0,1}  out  PHY_WIDTH  renamed tags.
- ren_ps1_rdy_{0,1}, ren_ps2_rdy_{0,1}  out  1  source ready (see Configuration).
- wb_valid  in  1  writeback tag valid.
- wb_phy  in  PHY_WIDTH  writeback tag.
- retire_valid  in  1  one retirement per cycle.
- retire_rd  in  ARCH_WIDTH  retiring architectural destination.
- retire_pd  in  PHY_WIDTH  retiring physical destination.
- fl_retire_valid  out  1  free-list commit strobe, combinational from retire_valid.
- fl_phy_old_commit, fl_phy_new_commit  out  PHY_WIDTH  old and new committed mappings.

## Operation
- Slot i needs allocation when dec_valid[i] && dec_rd_wen[i] && dec_rd_i != 0. Let need = number of slots needing allocation (0..2).
- fire = |dec_valid && (!(|ren_valid) || ren_ready) && fl_num_free >= need && !flush. dec_ready = fire.
- fl_valid[i] = fire && slot i needs allocation. The slot-1-only case uses fl_phy_new_1.
- Rename lookups read the front RAT. Source 0 always yields p0.
- Intra-group bypass: slot 1 rs1/rs2 equal to slot 0's allocating rd take slot 0's new tag. ren_pd_old_1 equals slot 0's new tag when both slots allocate the same rd.
- A non-allocating slot outputs ren_pd = 0 and ren_pd_old = 0.
- RAT update on fire: slot 0 is written, then slot 1. On a same-rd collision slot 1 wins.
- Committed RAT on retire_valid (retire_rd != 0):
  - fl_phy_old_commit = CRAT[retire_rd], read before update.
  - fl_phy_new_commit = retire_pd.
  - CRAT[retire_rd] <= retire_pd.
- A retire with retire_rd == 0 produces no strobe.
- Flush: front RAT <= CRAT including any same-cycle retire. ren_valid <= 0. No allocation occurs.
- Reset: RAT[i] = CRAT[i] = i; ren_valid = 0; all ren_* tags 0; dec_ready = 0. Physical tags 32..63 are the free-list initial content.

## Timing
- Output register has 1-cycle latency: group accepted at edge N appears on ren_* after edge N.
- Output holds stable while ren_valid != 0 and !ren_ready.
- Full back-pressure throughput is one group per cycle.
- fl_num_free < need stalls the whole group. Groups are never split.
- Priority: rst > flush > fire. Retire is processed independently of fire, including during stall.
- Reset mid-operation discards the in-flight group.

## Configuration
- RENAME_BUSY_TABLE_EN defined:
  - A PHY_REGS-bit busy table is compiled in.
  - Set on allocation; cleared by wb_valid; reset and flush clear all entries.
  - Ready bits are computed at rename and written into the output register.
  - A same-cycle wb clear is visible to the rename.
  - An intra-group bypassed source is not ready.
  - p0 is always ready.
- RENAME_BUSY_TABLE_EN undefined: all ren_*_rdy outputs are 0 and wb_* is ignored.

## Structure
- rename_pkg holds:
  - Parameters.
  - rename_slot_t (ps1, ps2, pd, pd_old, rdy bits).
  - The PHY_ZERO constant.
- Sub-module rat_table: ARCH_REGS x PHY_WIDTH array.
  - 4 read ports and 2 ordered write ports.
  - Bulk-load input for restore from CRAT.
  - Instantiated for the front RAT. The CRAT is a plain array in the top level.

## Test plan
- Reset, then slot 0 `rd=x5`, slot 1 `rs1=x5, rd=x5`, fl_phy_new=32/33 → ren_pd_0=32, pd_old_0=5; ren_ps1_1=32, pd_1=33, pd_old_1=32; RAT[5]=33.
- fl_num_free=1 with two allocating slots → dec_ready=0, fl_valid=0. fl_num_free=2 next cycle → accepted.
- ren_ready=0 for 3 cycles with a pending group → ren_* held stable, dec_ready=0.
- Retire x5→33, then flush with speculative x5→40 → fl_phy_old_commit=5. After flush, rename of rs1=x5 yields 33.
- Flush and retire x7→41 in the same cycle → front RAT[7]=41, ren_valid=0.
- With RENAME_BUSY_TABLE_EN: allocate p34, then wb_valid p34 → a later source read of that register reports ready=1. Before wb it reports 0.
